// File: rtl/conv_enc_pkg.sv
// conv_enc_pkg: shared constants, FSM encoding and config check for conv_encoder_param.
// Rev 1.0
`default_nettype none

package conv_enc_pkg;

   localparam int K_MAX_DEF = 9;
   localparam int N_MAX_DEF = 3;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ENC   = 3'd1,
      S_FLUSH = 3'd2,
      S_TBL   = 3'd3,
      S_DRAIN = 3'd4
   } enc_state_t;

   function automatic logic cfg_legal(input logic [3:0] k, input logic [1:0] n,
                                      input int k_max, input int n_max);
      return (int'(k) >= 3) && (int'(k) <= k_max) && (int'(n) >= 2) && (int'(n) <= n_max);
   endfunction

endpackage

`default_nettype wire

// File: rtl/conv_branch_calc.sv
// conv_branch_calc: combinational trellis branch (next state and codeword) for one input bit.
// Rev 1.0
`default_nettype none

module conv_branch_calc #(
   parameter int K_MAX = 9,
   parameter int N_MAX = 3
) (
   input  logic [K_MAX-2:0]       state,
   input  logic                   b,
   input  logic [N_MAX*K_MAX-1:0] polys,
   input  logic [3:0]             cfg_k,
   input  logic [1:0]             cfg_n,
   output logic [K_MAX-2:0]       nxt,
   output logic [N_MAX-1:0]       code
);

   logic [K_MAX-1:0] win;
   logic [K_MAX-1:0] kmask;

   always_comb begin
      win   = {state, b};
      kmask = '0;
      for (int i = 0; i < K_MAX; i++) begin
         kmask[i] = (i < int'(cfg_k));
      end
      // kmask shifted down by one keeps exactly the low K-1 state bits
      nxt  = win[K_MAX-2:0] & kmask[K_MAX-1:1];
      code = '0;
      for (int j = 0; j < N_MAX; j++) begin
         if (j < int'(cfg_n)) begin
            code[j] = ^(win & kmask & polys[j*K_MAX +: K_MAX]);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/conv_encoder_param.sv
// conv_encoder_param: runtime-configurable rate-1/N convolutional encoder and trellis table generator.
// Rev 1.0
`default_nettype none

module conv_encoder_param #(
   parameter int K_MAX = conv_enc_pkg::K_MAX_DEF,
   parameter int N_MAX = conv_enc_pkg::N_MAX_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en_c,
   input  logic                   mode_sel,
   input  logic [3:0]             cfg_k,
   input  logic [1:0]             cfg_n,
   input  logic                   term_en,
   input  logic [N_MAX*K_MAX-1:0] gen_poly,
   input  logic                   i_valid,
   output logic                   i_ready,
   input  logic                   i_bit,
   input  logic                   i_last,
   output logic                   o_valid,
   input  logic                   o_ready,
   output logic [N_MAX-1:0]       o_code,
   output logic                   o_last,
   output logic [K_MAX-2:0]       tbl_state,
   output logic [K_MAX-2:0]       tbl_nxt0,
   output logic [K_MAX-2:0]       tbl_nxt1,
   output logic [N_MAX-1:0]       tbl_code0,
   output logic [N_MAX-1:0]       tbl_code1,
   output logic                   busy,
   output logic                   cfg_err
);

   import conv_enc_pkg::*;

   localparam int SW = K_MAX - 1;

   enc_state_t st, st_nxt;

   logic                   term_r;
   logic [3:0]             k_r;
   logic [1:0]             n_r;
   logic [N_MAX*K_MAX-1:0] poly_r;
   logic [SW-1:0]          sreg, cnt, calc_state, nxt0, nxt1;
   logic [N_MAX-1:0]       code0, code1;
   logic                   adv, legal, start_ok, start_bad;
   logic                   enc_fire, flush_fire, tbl_fire, flush_last, tbl_last;

   assign legal      = cfg_legal(cfg_k, cfg_n, K_MAX, N_MAX);
   assign adv        = !o_valid || o_ready;
   assign start_ok   = (st == S_IDLE) && en_c && legal;
   assign start_bad  = (st == S_IDLE) && en_c && !legal;
   assign enc_fire   = (st == S_ENC) && adv && i_valid;
   assign flush_fire = (st == S_FLUSH) && adv;
   assign tbl_fire   = (st == S_TBL) && adv;
   assign flush_last = (int'(cnt) == int'(k_r) - 2);
   assign tbl_last   = (int'(cnt) == ((1 << (int'(k_r) - 1)) - 1));
   assign i_ready    = (st == S_ENC) && adv;
   assign busy       = (st != S_IDLE);

   // The table walk reuses the same two branch calculators, indexed by the entry counter
   assign calc_state = (st == S_TBL) ? cnt : sreg;

   conv_branch_calc #(.K_MAX(K_MAX), .N_MAX(N_MAX)) u_br0 (
      .state(calc_state), .b(1'b0), .polys(poly_r), .cfg_k(k_r), .cfg_n(n_r),
      .nxt(nxt0), .code(code0)
   );

   conv_branch_calc #(.K_MAX(K_MAX), .N_MAX(N_MAX)) u_br1 (
      .state(calc_state), .b(1'b1), .polys(poly_r), .cfg_k(k_r), .cfg_n(n_r),
      .nxt(nxt1), .code(code1)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) st <= S_IDLE;
      else      st <= st_nxt;
   end

   always_comb begin
      st_nxt = st;
      case (st)
         S_IDLE:  if (start_ok) st_nxt = mode_sel ? S_TBL : S_ENC;
         S_ENC:   if (enc_fire && i_last) st_nxt = term_r ? S_FLUSH : S_DRAIN;
         S_FLUSH: if (flush_fire && flush_last) st_nxt = S_DRAIN;
         S_TBL:   if (tbl_fire && tbl_last) st_nxt = S_DRAIN;
         S_DRAIN: if (!o_valid) st_nxt = S_IDLE;
         default: st_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         term_r    <= 1'b0;
         k_r       <= '0;
         n_r       <= '0;
         poly_r    <= '0;
         sreg      <= '0;
         cnt       <= '0;
         cfg_err   <= 1'b0;
         o_valid   <= 1'b0;
         o_code    <= '0;
         o_last    <= 1'b0;
         tbl_state <= '0;
         tbl_nxt0  <= '0;
         tbl_nxt1  <= '0;
         tbl_code0 <= '0;
         tbl_code1 <= '0;
      end else begin
         if (start_bad) cfg_err <= 1'b1;
         if (start_ok) begin
            cfg_err <= 1'b0;
            term_r  <= term_en;
            k_r     <= cfg_k;
            n_r     <= cfg_n;
            poly_r  <= gen_poly;
            sreg    <= '0;
            cnt     <= '0;
         end
         if (enc_fire) begin
            o_valid <= 1'b1;
            o_code  <= i_bit ? code1 : code0;
            o_last  <= i_last && !term_r;
            sreg    <= i_bit ? nxt1 : nxt0;
         end else if (flush_fire) begin
            o_valid <= 1'b1;
            o_code  <= code0;
            o_last  <= flush_last;
            sreg    <= nxt0;
            cnt     <= cnt + SW'(1);
         end else if (tbl_fire) begin
            o_valid   <= 1'b1;
            o_code    <= '0;
            o_last    <= tbl_last;
            tbl_state <= cnt;
            tbl_nxt0  <= nxt0;
            tbl_nxt1  <= nxt1;
            tbl_code0 <= code0;
            tbl_code1 <= code1;
            cnt       <= cnt + SW'(1);
         end else if (o_valid && o_ready) begin
            o_valid <= 1'b0;
            o_code  <= '0;
            o_last  <= 1'b0;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_conv_encoder_param.sv
// tb_conv_encoder_param: golden vectors plus randomized streams/tables against a convolution-sum model.
// Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_conv_encoder_param;

   localparam int KM = 9;
   localparam int NM = 3;
   localparam int SW = KM - 1;
   localparam logic [NM*KM-1:0] G75 = {9'd0, 9'd5, 9'd7};

   logic clk = 1'b0, rst = 1'b1;
   logic en_c = 1'b0, mode_sel = 1'b0, term_en = 1'b0;
   logic i_valid = 1'b0, i_bit = 1'b0, i_last = 1'b0, o_ready = 1'b0;
   logic [3:0] cfg_k = '0;
   logic [1:0] cfg_n = '0;
   logic [NM*KM-1:0] gen_poly = '0;
   logic i_ready, o_valid, o_last, busy, cfg_err;
   logic [NM-1:0] o_code, tbl_code0, tbl_code1;
   logic [SW-1:0] tbl_state, tbl_nxt0, tbl_nxt1;

   int checks = 0;
   int errors = 0;

   typedef struct { logic [2:0] code; logic last; } word_t;
   typedef struct { int nx0; logic [2:0] c0; int nx1; logic [2:0] c1; } tent_t;

   word_t gold_term[6];
   word_t gold_noterm[4];
   tent_t gold_tbl[4];

   bit         q_bits[$];
   logic [2:0] q_code[$];
   logic       q_last[$];

   always #5 clk = ~clk;

   conv_encoder_param dut (
      .clk(clk), .rst(rst), .en_c(en_c), .mode_sel(mode_sel), .cfg_k(cfg_k), .cfg_n(cfg_n),
      .term_en(term_en), .gen_poly(gen_poly), .i_valid(i_valid), .i_ready(i_ready),
      .i_bit(i_bit), .i_last(i_last), .o_valid(o_valid), .o_ready(o_ready), .o_code(o_code),
      .o_last(o_last), .tbl_state(tbl_state), .tbl_nxt0(tbl_nxt0), .tbl_nxt1(tbl_nxt1),
      .tbl_code0(tbl_code0), .tbl_code1(tbl_code1), .busy(busy), .cfg_err(cfg_err)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Codeword at time t is the sum over taps i of g_j[i] * x[t-i], x zero outside the block
   function automatic void model_stream(input int k, input int n, input logic [NM*KM-1:0] g,
                                        input logic term);
      int nb;
      int total;
      logic [2:0] c;
      nb = q_bits.size();
      total = nb + (term ? k - 1 : 0);
      q_code.delete();
      q_last.delete();
      for (int t = 0; t < total; t++) begin
         c = '0;
         for (int j = 0; j < n; j++)
            for (int i = 0; i < k; i++)
               if (t - i >= 0 && t - i < nb) c[j] = c[j] ^ (g[j*KM+i] & q_bits[t-i]);
         q_code.push_back(c);
         q_last.push_back(t == total - 1);
      end
   endfunction

   function automatic void tmodel(input int k, input int n, input logic [NM*KM-1:0] g,
                                  input int s, input int b, output int nx, output logic [2:0] c);
      int w;
      int gj;
      w  = (s * 2) + b;
      nx = w % (1 << (k - 1));
      c  = '0;
      for (int j = 0; j < n; j++) begin
         gj = int'(g[j*KM +: KM]) % (1 << k);
         c[j] = $countones(w & gj) % 2;
      end
   endfunction

   task automatic start(input logic mode, input int k, input int n, input logic term,
                        input logic [NM*KM-1:0] g);
      @(negedge clk);
      en_c = 1'b1; mode_sel = mode; cfg_k = 4'(k); cfg_n = 2'(n); term_en = term; gen_poly = g;
      i_valid = 1'b0; i_last = 1'b0;
      @(negedge clk);
      en_c = 1'b0;
   endtask

   task automatic busy_tail(input string tag);
      @(negedge clk);
      check({tag, " busy_drain"}, {busy, o_valid}, 2'b10);
      @(negedge clk);
      check({tag, " busy_idle"}, busy, 1'b0);
   endtask

   // pmode 0: always ready; 1: 3-cycle stall after two words; 2: random handshakes and scrambled config
   task automatic run_stream(input string tag, input int pmode, input int abort_at, input int k,
                             input int n, input logic term, input logic [NM*KM-1:0] g);
      int acc, got, cyc, stall, nb;
      logic hold;
      logic [2:0] held;
      acc = 0; got = 0; cyc = 0; stall = 0; nb = q_bits.size(); hold = 1'b0; held = '0;
      start(1'b0, k, n, term, g);
      while (got < q_code.size() && !(abort_at >= 0 && got >= abort_at)) begin
         @(negedge clk);
         cyc++;
         if (cyc > 3000) begin
            check({tag, " timeout"}, got, q_code.size());
            break;
         end
         case (pmode)
            1: begin
               o_ready = !(got == 2 && stall < 3);
               if (!o_ready) stall++;
            end
            2: o_ready = ($urandom_range(0, 3) != 0);
            default: o_ready = 1'b1;
         endcase
         if (pmode == 2) begin
            en_c = 1'($urandom); mode_sel = 1'($urandom); term_en = 1'($urandom);
            cfg_k = 4'($urandom); cfg_n = 2'($urandom); gen_poly = 27'($urandom);
         end
         i_valid = (acc < nb) && (pmode != 2 || $urandom_range(0, 1) == 1);
         i_bit   = (acc < nb) ? q_bits[acc] : 1'b0;
         i_last  = (acc == nb - 1);
         #1;
         check({tag, " i_ready"}, i_ready, (acc < nb) && (!o_valid || o_ready));
         if (hold) check({tag, " hold"}, {o_valid, o_code}, {1'b1, held});
         if (o_valid && o_ready) begin
            check({tag, " code"}, o_code, q_code[got]);
            check({tag, " last"}, o_last, q_last[got]);
            got++;
         end
         hold = o_valid && !o_ready;
         held = o_code;
         if (i_ready && i_valid) acc++;
      end
      en_c = 1'b0; i_valid = 1'b0; i_last = 1'b0;
      if (abort_at < 0) busy_tail(tag);
   endtask

   task automatic run_table(input string tag, input int pmode, input logic use_gold, input int k,
                            input int n, input logic [NM*KM-1:0] g);
      int s, cyc, nent, nx0, nx1;
      logic [2:0] c0, c1;
      logic hold;
      logic [SW-1:0] held;
      s = 0; cyc = 0; nent = 1 << (k - 1); hold = 1'b0; held = '0;
      start(1'b1, k, n, 1'b0, g);
      while (s < nent) begin
         @(negedge clk);
         cyc++;
         if (cyc > 3000) begin
            check({tag, " timeout"}, s, nent);
            break;
         end
         o_ready = (pmode == 2) ? ($urandom_range(0, 2) != 0) : 1'b1;
         #1;
         check({tag, " i_ready"}, i_ready, 1'b0);
         if (hold) check({tag, " hold"}, {o_valid, tbl_state}, {1'b1, held});
         if (o_valid && o_ready) begin
            if (use_gold) begin
               nx0 = gold_tbl[s].nx0; c0 = gold_tbl[s].c0; nx1 = gold_tbl[s].nx1; c1 = gold_tbl[s].c1;
            end else begin
               tmodel(k, n, g, s, 0, nx0, c0);
               tmodel(k, n, g, s, 1, nx1, c1);
            end
            check({tag, " state"}, tbl_state, s);
            check({tag, " nxt0"}, tbl_nxt0, nx0);
            check({tag, " nxt1"}, tbl_nxt1, nx1);
            check({tag, " code0"}, tbl_code0, c0);
            check({tag, " code1"}, tbl_code1, c1);
            check({tag, " o_code"}, o_code, 0);
            check({tag, " last"}, o_last, s == nent - 1);
            s++;
         end
         hold = o_valid && !o_ready;
         held = tbl_state;
      end
      busy_tail(tag);
   endtask

   task automatic illegal_start(input string tag, input int k, input int n);
      start(1'b0, k, n, 1'b1, G75);
      #1;
      check({tag, " cfg_err"}, cfg_err, 1'b1);
      check({tag, " busy"}, busy, 1'b0);
      @(negedge clk);
      check({tag, " stays_idle"}, {busy, i_ready, o_valid}, 3'b000);
   endtask

   task automatic load_gold(input int which);
      q_code.delete();
      q_last.delete();
      q_bits = '{1'b1, 1'b0, 1'b1, 1'b1};
      if (which == 0) begin
         foreach (gold_term[i]) begin q_code.push_back(gold_term[i].code); q_last.push_back(gold_term[i].last); end
      end else begin
         foreach (gold_noterm[i]) begin q_code.push_back(gold_noterm[i].code); q_last.push_back(gold_noterm[i].last); end
      end
   endtask

   task automatic rand_bits(input int nb);
      q_bits.delete();
      for (int i = 0; i < nb; i++) q_bits.push_back(1'($urandom));
   endtask

   function automatic logic [37:0] all_outs();
      return {i_ready, o_valid, o_code, o_last, tbl_state, tbl_nxt0, tbl_nxt1,
              tbl_code0, tbl_code1, busy, cfg_err};
   endfunction

   initial begin
      int k, n, nb;
      logic term;
      logic [NM*KM-1:0] g;

      // o_code = {c2,c1,c0}
      gold_term[0] = '{3'b011, 1'b0}; gold_term[1] = '{3'b001, 1'b0}; gold_term[2] = '{3'b000, 1'b0};
      gold_term[3] = '{3'b010, 1'b0}; gold_term[4] = '{3'b010, 1'b0}; gold_term[5] = '{3'b011, 1'b1};
      gold_noterm[0] = '{3'b011, 1'b0}; gold_noterm[1] = '{3'b001, 1'b0};
      gold_noterm[2] = '{3'b000, 1'b0}; gold_noterm[3] = '{3'b010, 1'b1};
      gold_tbl[0] = '{0, 3'b000, 1, 3'b011};
      gold_tbl[1] = '{2, 3'b001, 3, 3'b010};
      gold_tbl[2] = '{0, 3'b011, 1, 3'b000};
      gold_tbl[3] = '{2, 3'b010, 3, 3'b001};

      #2 rst = 1'b0;
      repeat (3) @(negedge clk);
      check("reset outputs", all_outs(), '0);
      rst = 1'b1;

      load_gold(0); run_stream("enc_term", 0, -1, 3, 2, 1'b1, G75);
      load_gold(1); run_stream("enc_noterm", 0, -1, 3, 2, 1'b0, G75);
      load_gold(0); run_stream("backpressure", 1, -1, 3, 2, 1'b1, G75);
      run_table("tbl_k3", 0, 1'b1, 3, 2, G75);

      illegal_start("bad_k", 2, 2);
      illegal_start("bad_n", 3, 1);
      illegal_start("big_k", 10, 3);
      rand_bits(6); model_stream(5, 3, 27'h5a3c1f7, 1'b1);
      run_stream("after_err", 0, -1, 5, 3, 1'b1, 27'h5a3c1f7);
      check("cfg_err cleared", cfg_err, 1'b0);

      for (int it = 0; it < 8; it++) begin
         k = $urandom_range(3, 9); n = $urandom_range(2, 3); term = 1'($urandom);
         g = 27'($urandom); nb = $urandom_range(1, 24);
         rand_bits(nb); model_stream(k, n, g, term);
         run_stream("rand_enc", 2, -1, k, n, term, g);
      end

      for (int it = 0; it < 3; it++) begin
         k = $urandom_range(3, 7); n = $urandom_range(2, 3); g = 27'($urandom);
         run_table("rand_tbl", 2, 1'b0, k, n, g);
      end

      g = 27'($urandom);
      rand_bits(10); model_stream(9, 3, g, 1'b1);
      run_stream("rst_flush", 0, 12, 9, 3, 1'b1, g);
      #1;
      check("rst_flush busy before reset", busy, 1'b1);
      rst = 1'b0;
      #1;
      check("rst_flush outputs", all_outs(), '0);
      @(negedge clk);
      rst = 1'b1;
      rand_bits(10); model_stream(9, 3, g, 1'b1);
      run_stream("restart", 0, -1, 9, 3, 1'b1, g);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
